// File: rtl/pipe_stage_reg.sv
// Pipeline-stage register with valid/ready handshake, flush and gated ctrl.
// Define PIPE_SKID_EN for a 2-entry skid buffer with a registered in_ready.
module pipe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic              in_fire, out_fire;

    assign out_valid = (state_q != EMPTY);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign out_data  = main_data_q;
    // An empty stage must never assert a write or branch downstream.
    assign out_ctrl  = out_valid ? main_ctrl_q : '0;

`ifdef PIPE_SKID_EN

    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic              in_ready_q, in_ready_d;

    assign in_ready  = in_ready_q;
    assign occupancy = state_q;

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        main_data_d = in_data;
                        main_ctrl_d = in_ctrl;
                        state_d     = ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_data_d = in_data;
                        main_ctrl_d = in_ctrl;
                    end else if (in_fire) begin
                        skid_data_d = in_data;
                        skid_ctrl_d = in_ctrl;
                        state_d     = TWO;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (out_fire) begin
                        main_data_d = skid_data_q;
                        main_ctrl_d = skid_ctrl_q;
                        state_d     = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
        // Registered ready: decided from next state, never from out_ready.
        in_ready_d = (state_d != TWO);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
            in_ready_q  <= 1'b1;
        end else begin
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            in_ready_q  <= in_ready_d;
        end
    end

`else

    assign in_ready  = !out_valid || out_ready;
    assign occupancy = {1'b0, out_valid};

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY, ONE: begin
                    if (in_fire) begin
                        main_data_d = in_data;
                        main_ctrl_d = in_ctrl;
                        state_d     = ONE;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= EMPTY;
            main_data_q <= '0;
            main_ctrl_q <= '0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_ctrl_q <= main_ctrl_d;
        end
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline-stage register with valid/ready handshake, synchronous flush and bubble-gated control outputs. It replaces the fixed-width, always-loading inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) between any two pipeline stages. It adds stall back-pressure, hazard flush and an optional 2-entry skid buffer that breaks the combinational ready path.

## Interface
Parameters:
- DATA_W, 32: width of the datapath bundle (ALU result, store data, addresses, dest reg, concatenated by the instantiating stage).
- CTRL_W, 5: width of the control bundle (Branch, MemRead, MemWrite, MemtoReg, RegWrite, …).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous kill of all held entries and of the same-cycle input.
- in_valid  in  1  upstream entry present.
- in_ready  out  1  stage can accept an entry this cycle.
- in_data  in  DATA_W  upstream datapath bundle.
- in_ctrl  in  CTRL_W  upstream control bundle.
- out_valid  out  1  entry presented downstream.
- out_ready  in  1  downstream consumes the entry this cycle.
- out_data  out  DATA_W  held datapath bundle.
- out_ctrl  out  CTRL_W  held control bundle, forced to 0 when out_valid=0.
- occupancy  out  2  number of held entries (0..2).

## Operation
- Transfer in: in_valid && in_ready at a rising edge. Transfer out: out_valid && out_ready.
- Bubble gating: out_ctrl = out_valid ? main_ctrl : 0. No write or branch is ever asserted by an empty stage. out_data is not gated.
- With skid (see Configuration), the stage holds a main entry and a skid entry. States are EMPTY (occ 0), ONE (occ 1, main valid) and TWO (occ 2, main+skid valid).
  - EMPTY: in transfer → main←in, ONE.
  - ONE, in and out transfer: main←in, stay ONE.
  - ONE, in only: skid←in, TWO.
  - ONE, out only: EMPTY.
  - TWO: in_ready=0. Out transfer → main←skid, ONE.
- in_ready is a register: 1 in EMPTY and ONE, 0 in TWO. It has no combinational dependence on out_ready.
- Ordering is strictly FIFO; no entry is duplicated or dropped except by flush.
- Flush has the highest priority. At the edge it sets state EMPTY and occupancy 0. Any input handshaking in that cycle is discarded.
  - Data registers keep stale values; they are don't-care because ctrl is gated.
  - in_ready is 1 the cycle after a flush.
- Out transfer on a flushed entry in the flush cycle still counts for downstream; the stage only guarantees state after the edge.

## Timing
- Reset (async, immediate): state EMPTY, out_valid=0, out_ctrl=0, out_data=0, skid data=0, occupancy=0, in_ready=1.
- Latency: 1 cycle. An entry accepted at edge N is on out_* after edge N.
- Throughput: 1 entry/cycle when out_ready is held high.
- Stall: out_ready=0 holds out_data/out_ctrl stable. With skid, one further entry is absorbed, then in_ready drops the cycle after.
- Release from TWO: in_ready returns 1 one cycle after the first out transfer.
- Simultaneous in+out transfer in ONE does not change occupancy.
- rst deasserted mid-stream: the stage resumes from EMPTY; upstream must re-present.

## Configuration
- PIPE_SKID_EN defined: 2-entry skid behaviour as above; occupancy 0..2; in_ready registered.
- PIPE_SKID_EN undefined: single entry only (states EMPTY/ONE).
  - in_ready = !out_valid || out_ready, combinational.
  - occupancy ≤ 1.
  - Flush, bubble gating, reset and latency are unchanged.

## Test plan
- Reset then stream: drive in_data=0x10..0x17 with in_valid=1 and out_ready=1. Expect out_data 0x10..0x17 on consecutive cycles, 1-cycle latency, occupancy=1.
- Stall: out_ready=0 while in_valid=1 with 0xA0,0xA1,0xA2. With skid, expect occupancy=2 and in_ready=0, 0xA2 not accepted. Then out_ready=1 gives output 0xA0,0xA1,0xA2 in order. Without skid, in_ready=0 immediately and occupancy=1.
- Flush in TWO with a concurrent input: next cycle out_valid=0, out_ctrl=0, occupancy=0, in_ready=1. The discarded input never appears.
- Bubble gating: in_ctrl=5'b11111 with in_valid=0 → out_ctrl stays 0.
- Async reset mid-stall (occupancy 2): out_valid and occupancy drop to 0 without a clock edge. Output values equal reset values.
